// File: rtl/rect_stream_if.sv
// Rectangle stream bus: copy-controller stream in, register-file write port and status out.
interface rect_stream_if;
  logic        copy_start;
  logic [15:0] rect_din;
  logic        wr_en;
  logic [2:0]  wr_field;
  logic [5:0]  wr_index;
  logic [15:0] wr_data;
  logic [2:0]  phase_out;
  logic        in_window;
  logic        frame_done;
  logic        range_error;

  modport master (
    output copy_start, rect_din,
    input  wr_en, wr_field, wr_index, wr_data, phase_out, in_window, frame_done, range_error
  );
  modport slave (
    input  copy_start, rect_din,
    output wr_en, wr_field, wr_index, wr_data, phase_out, in_window, frame_done, range_error
  );
endinterface

// File: rtl/rect_stream_receiver.sv
// Follows the fixed-timing rectangle DMA stream and writes each value into the GPU rect register file.
// Optional sticky coordinate range check enabled by RECT_RX_RANGE_CHECK_EN.
module rect_stream_receiver #(
  parameter int FIRST_OFFSET = 4,
  parameter int STRIDE       = 3,
  parameter int GAP_EXTRA    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  rect_stream_if.slave  bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LEAD   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_WINDOW = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [3:0]  rect_q, rect_d;
  logic [1:0]  batch_q, batch_d;
  logic [2:0]  phase_q, phase_d;
  logic        wr_en_q, wr_en_d;
  logic [2:0]  wr_field_q, wr_field_d;
  logic [5:0]  wr_index_q, wr_index_d;
  logic [15:0] wr_data_q, wr_data_d;
  logic        frame_done_q, frame_done_d;
  logic        sample;

  // Window counter reload: counts down to 1 so the next sample lands W+GAP_EXTRA after the last.
  function automatic logic [9:0] gap_len(input logic [2:0] ph);
    case (ph)
      3'd1, 3'd2: gap_len = 10'(640 + GAP_EXTRA - 1);
      3'd3, 3'd4: gap_len = 10'(480 + GAP_EXTRA - 1);
      default:    gap_len = 10'(16 + GAP_EXTRA - 1);
    endcase
  endfunction

`ifdef RECT_RX_RANGE_CHECK_EN
  logic        range_error_q, range_error_d;
  logic [15:0] limit;
  assign limit = (phase_q <= 3'd2) ? 16'd640 : 16'd480;
`endif

  assign sample = (state_q == S_SAMPLE) && (cnt_q == 10'd0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rect_d       = rect_q;
    batch_d      = batch_q;
    phase_d      = phase_q;
    wr_en_d      = 1'b0;
    wr_field_d   = wr_field_q;
    wr_index_d   = wr_index_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;
`ifdef RECT_RX_RANGE_CHECK_EN
    range_error_d = range_error_q;
`endif
    case (state_q)
      S_IDLE: begin
        // The cycle showing frame_done still refuses a new start.
        if (bus.copy_start && !frame_done_q) begin
          state_d = S_LEAD;
          cnt_d   = 10'(FIRST_OFFSET - 2);
          rect_d  = 4'd0;
          batch_d = 2'd0;
          phase_d = 3'd1;
`ifdef RECT_RX_RANGE_CHECK_EN
          range_error_d = 1'b0;
`endif
        end
      end
      S_LEAD: begin
        if (cnt_q == 10'd0) state_d = S_SAMPLE;
        else                cnt_d   = cnt_q - 10'd1;
      end
      S_SAMPLE: begin
        if (!sample) begin
          cnt_d = cnt_q - 10'd1;
        end else begin
          wr_en_d    = 1'b1;
          wr_field_d = phase_q - 3'd1;
          wr_index_d = {batch_q, rect_q};
          wr_data_d  = bus.rect_din;
`ifdef RECT_RX_RANGE_CHECK_EN
          // A 16-bit compare also catches any nonzero bit above the 10-bit coordinate.
          if (phase_q != 3'd5 && bus.rect_din > limit) range_error_d = 1'b1;
`endif
          if (rect_q == 4'd15) begin
            state_d = S_WINDOW;
            rect_d  = 4'd0;
            cnt_d   = gap_len(phase_q);
          end else begin
            rect_d = rect_q + 4'd1;
            cnt_d  = 10'(STRIDE - 1);
          end
        end
      end
      default: begin
        if (cnt_q == 10'd1) begin
          cnt_d   = 10'd0;
          batch_d = batch_q + 2'd1;
          state_d = S_SAMPLE;
          if (batch_q == 2'd3) begin
            if (phase_q == 3'd5) begin
              state_d      = S_IDLE;
              phase_d      = 3'd0;
              frame_done_d = 1'b1;
            end else begin
              phase_d = phase_q + 3'd1;
            end
          end
        end else begin
          cnt_d = cnt_q - 10'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rect_q       <= '0;
      batch_q      <= '0;
      phase_q      <= '0;
      wr_en_q      <= 1'b0;
      wr_field_q   <= '0;
      wr_index_q   <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rect_q       <= rect_d;
      batch_q      <= batch_d;
      phase_q      <= phase_d;
      wr_en_q      <= wr_en_d;
      wr_field_q   <= wr_field_d;
      wr_index_q   <= wr_index_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
    end
  end

`ifdef RECT_RX_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset_n) range_error_q <= 1'b0;
    else          range_error_q <= range_error_d;
  end
  assign bus.range_error = range_error_q;
`else
  assign bus.range_error = 1'b0;
`endif

  assign bus.wr_en      = wr_en_q;
  assign bus.wr_field   = wr_field_q;
  assign bus.wr_index   = wr_index_q;
  assign bus.wr_data    = wr_data_q;
  assign bus.phase_out  = phase_q;
  assign bus.in_window  = (state_q == S_WINDOW);
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_rect_stream_receiver.sv
// Directed bench for rect_stream_receiver: frame timing, ignored starts, mid-frame reset, range check.
module tb_rect_stream_receiver;
  logic clk;
  logic reset_n;
  rect_stream_if bus();

  rect_stream_receiver dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned gcyc = 0;
  int unsigned s0   = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) gcyc <= gcyc + 1;

  // Stream source: 0 = X, 1 = ramp of the global cycle, 2 = constant.
  int          din_mode  = 0;
  logic [15:0] din_const = '0;
  always @(negedge clk) begin
    if (din_mode == 0)      bus.rect_din = 'x;
    else if (din_mode == 1) bus.rect_din = gcyc[15:0];
    else                    bus.rect_din = din_const;
  end

  // Write monitor: each frame must write field f, index i in order f*64+i.
  logic mon_clr = 1'b0;
  int   wcount = 0, order_err = 0, fd_count = 0;
  always @(posedge clk) begin
    if (mon_clr) begin
      wcount = 0; order_err = 0; fd_count = 0;
    end else begin
      if (bus.wr_en === 1'b1) begin
        if (bus.wr_field !== 3'((wcount % 320) / 64) || bus.wr_index !== 6'(wcount % 64))
          order_err++;
        wcount++;
      end
      if (bus.frame_done === 1'b1) fd_count++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic goto(input int unsigned c);
    while (gcyc - s0 < c) @(negedge clk);
  endtask

  task automatic clr_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
  endtask

  task automatic start();
    s0 = gcyc;
    bus.copy_start = 1'b1;
    goto(1);
    bus.copy_start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.copy_start = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", 32'(bus.wr_en), 0);
    chk("rst_wr_data_noX", 32'(bus.wr_data), 0);
    chk("rst_phase", 32'(bus.phase_out), 0);
    chk("rst_window", 32'(bus.in_window), 0);
    chk("rst_done", 32'(bus.frame_done), 0);
    chk("rst_range", 32'(bus.range_error), 0);

    // Frame A: ramp data, stray starts mid-window and at the end.
    din_mode = 1;
    clr_mon();
    start();
    chk("A_phase1", 32'(bus.phase_out), 1);
    goto(4);  chk("A_no_wr_c4", 32'(bus.wr_en), 0);
    goto(5);
    chk("A_wr_c5", 32'(bus.wr_en), 1);
    chk("A_field_c5", 32'(bus.wr_field), 0);
    chk("A_index_c5", 32'(bus.wr_index), 0);
    chk("A_data_c5", 32'(bus.wr_data), 32'(16'(s0 + 4)));
    goto(49); chk("A_win_c49", 32'(bus.in_window), 0);
    goto(50);
    chk("A_wr_c50", 32'(bus.wr_en), 1);
    chk("A_index_c50", 32'(bus.wr_index), 15);
    chk("A_data_c50", 32'(bus.wr_data), 32'(16'(s0 + 49)));
    chk("A_win_c50", 32'(bus.in_window), 1);
    goto(300); bus.copy_start = 1'b1;
    goto(301); bus.copy_start = 1'b0;
    chk("A_win_c301", 32'(bus.in_window), 1);
    chk("A_phase_c301", 32'(bus.phase_out), 1);
    goto(691); chk("A_win_c691", 32'(bus.in_window), 1);
    goto(692); chk("A_win_c692", 32'(bus.in_window), 0);
    goto(693);
    chk("A_wr_c693", 32'(bus.wr_en), 1);
    chk("A_index_c693", 32'(bus.wr_index), 16);
    chk("A_data_c693", 32'(bus.wr_data), 32'(16'(s0 + 692)));
    goto(9970);
    chk("A_last_wr", 32'(bus.wr_en), 1);
    chk("A_last_field", 32'(bus.wr_field), 4);
    chk("A_last_index", 32'(bus.wr_index), 63);
    goto(9987); bus.copy_start = 1'b1;
    chk("A_done_c9987", 32'(bus.frame_done), 0);
    chk("A_win_c9987", 32'(bus.in_window), 1);
    goto(9988);
    chk("A_done_c9988", 32'(bus.frame_done), 1);
    chk("A_phase_c9988", 32'(bus.phase_out), 0);
    chk("A_win_c9988", 32'(bus.in_window), 0);
    goto(9989); bus.copy_start = 1'b0;
    chk("A_done_c9989", 32'(bus.frame_done), 0);
    chk("A_phase_c9989", 32'(bus.phase_out), 0);
    goto(10100);
    chk("A_wcount", 32'(wcount), 320);
    chk("A_order", 32'(order_err), 0);
    chk("A_fd_count", 32'(fd_count), 1);
    chk("A_range", 32'(bus.range_error), 0);

    // Frame B: a start in IDLE replays the identical frame.
    start();
    goto(5);
    chk("B_wr_c5", 32'(bus.wr_en), 1);
    chk("B_index_c5", 32'(bus.wr_index), 0);
    goto(9988); chk("B_done_c9988", 32'(bus.frame_done), 1);
    goto(10000);
    chk("B_wcount", 32'(wcount), 640);
    chk("B_order", 32'(order_err), 0);
    chk("B_fd_count", 32'(fd_count), 2);

    // Reset during phase Y batch 2.
    clr_mon();
    start();
    goto(6565); chk("R_phase_Y", 32'(bus.phase_out), 3);
    goto(6570); reset_n = 1'b0;
    goto(6571); reset_n = 1'b1;
    chk("R_wr_en", 32'(bus.wr_en), 0);
    chk("R_field", 32'(bus.wr_field), 0);
    chk("R_index", 32'(bus.wr_index), 0);
    chk("R_data", 32'(bus.wr_data), 0);
    chk("R_phase", 32'(bus.phase_out), 0);
    chk("R_window", 32'(bus.in_window), 0);
    chk("R_done", 32'(bus.frame_done), 0);
    clr_mon();
    goto(7200);
    chk("R_no_done", 32'(fd_count), 0);
    chk("R_no_wr", 32'(wcount), 0);
    start();
    goto(5);
    chk("R2_wr_c5", 32'(bus.wr_en), 1);
    chk("R2_field_c5", 32'(bus.wr_field), 0);
    chk("R2_index_c5", 32'(bus.wr_index), 0);
    goto(9990);
    chk("R2_wcount", 32'(wcount), 320);
    chk("R2_fd_count", 32'(fd_count), 1);
    chk("R2_order", 32'(order_err), 0);

`ifdef RECT_RX_RANGE_CHECK_EN
    // 641 on the first X sample, then legal values; colors 0xFFFF.
    din_mode = 2; din_const = 16'd641;
    start();
    goto(4); chk("E_pre", 32'(bus.range_error), 0);
    goto(5); din_const = 16'd100;
    chk("E_set", 32'(bus.range_error), 1);
    goto(9500); din_const = 16'hFFFF;
    goto(9990); chk("E_held", 32'(bus.range_error), 1);
    din_const = 16'd640;
    start();
    chk("E_clear", 32'(bus.range_error), 0);
    goto(5000); din_const = 16'd480;
    goto(9500); din_const = 16'hFFFF;
    goto(9990);
    chk("E_limits_ok", 32'(bus.range_error), 0);
    chk("E_done", 32'(fd_count), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
